// File: rtl/avl_pkg.sv
// Shared defaults and FSM encoding for the Avalon memory responder.
package avl_pkg;

    localparam int AVL_ADDR_W = 26;
    localparam int AVL_DATA_W = 128;
    localparam int AVL_WCNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/avl_resp_ram.sv
// Single-port backing store: synchronous write, registered read.
module avl_resp_ram #(
    parameter int DATA_W = 128,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    // No reset here so the array maps onto block RAM and survives reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM memory slave with wait states, fixed read latency and error flags.
module avl_mem_responder
    import avl_pkg::*;
#(
    parameter int ADDR_W       = AVL_ADDR_W,
    parameter int DATA_W       = AVL_DATA_W,
    parameter int MEM_AW       = 10,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] avl_address,
    input  logic              avl_read,
    input  logic              avl_write,
    input  logic [DATA_W-1:0] avl_writedata,
    output logic              avl_wait,
    output logic [DATA_W-1:0] avl_readdata,
    output logic              avl_readdatavalid,
    output logic              err_oor,
    output logic              err_proto,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    state_t                state;
    logic [AVL_WCNT_W-1:0] cnt;
    logic                  wait_q;

    logic acc;
    logic wr_acc;
    logic rd_acc;
    logic oor;
    logic proto;

    assign oor    = |avl_address[ADDR_W-1:MEM_AW];
    assign acc    = !wait_q && (avl_read || avl_write);
    assign wr_acc = acc && avl_write;
    assign rd_acc = acc && avl_read && !avl_write;
    assign proto  = acc && avl_read && avl_write;

    assign avl_wait = wait_q;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state  <= IDLE;
            cnt    <= '0;
            wait_q <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    wait_q <= 1'b0;
                    if (acc && WAIT_CYCLES != 0) begin
                        state  <= BUSY;
                        wait_q <= 1'b1;
                        cnt    <= AVL_WCNT_W'(WAIT_CYCLES);
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == AVL_WCNT_W'(1)) begin
                        state  <= IDLE;
                        wait_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    wait_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            err_oor   <= 1'b0;
            err_proto <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (acc && oor) begin
                err_oor <= 1'b1;
            end
            if (proto) begin
                err_proto <= 1'b1;
            end
            if (rd_acc) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_acc) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    logic [DATA_W-1:0] ram_q;

    avl_resp_ram #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk   (iCLK),
        .we    (wr_acc && !oor),
        .re    (rd_acc && !oor),
        .addr  (avl_address[MEM_AW-1:0]),
        .wdata (avl_writedata),
        .q     (ram_q)
    );

    // Stage 1 is the RAM output register; oor reads are zeroed here.
    logic              v1;
    logic              o1;
    logic [DATA_W-1:0] d1;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            v1 <= 1'b0;
            o1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
            o1 <= rd_acc && oor;
        end
    end

    assign d1 = o1 ? '0 : ram_q;

    logic              vt;
    logic [DATA_W-1:0] dt;

    if (READ_LATENCY == 1) begin : gen_l1
        assign vt = v1;
        assign dt = d1;
    end else begin : gen_pipe
        logic [READ_LATENCY-2:0] vs;
        logic [DATA_W-1:0]       ds [READ_LATENCY-1];

        always_ff @(posedge iCLK or negedge iRST_n) begin
            if (!iRST_n) begin
                vs <= '0;
            end else begin
                vs[0] <= v1;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    vs[i] <= vs[i-1];
                end
            end
        end

        always_ff @(posedge iCLK) begin
            ds[0] <= d1;
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
                ds[i] <= ds[i-1];
            end
        end

        assign vt = vs[READ_LATENCY-2];
        assign dt = ds[READ_LATENCY-2];
    end

    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hold_q <= '0;
        end else if (vt) begin
            hold_q <= dt;
        end
    end

    assign avl_readdatavalid = vt;
    assign avl_readdata      = vt ? dt : hold_q;

endmodule

// File: doc/avl_mem_responder.md
AVL_MEM_RESPONDER -- requirements
Module: avl_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 26, sets the Avalon word-address width.
REQ-002 Parameter DATA_W, default 128, sets the Avalon data width.
REQ-003 Parameter MEM_AW, default 10, sets the backing-store index width; depth is 2**MEM_AW words.
REQ-004 Parameter WAIT_CYCLES, default 2, range 0..15, sets the wait states inserted after each accepted command.
REQ-005 Parameter READ_LATENCY, default 2, range 1..8, sets the cycles from read accept to data valid.
REQ-006 iCLK  in  1  sole clock; all state changes on its rising edge.
REQ-007 iRST_n  in  1  reset; asynchronous assertion, active-low.
REQ-008 avl_address  in  ADDR_W  word address from the master.
REQ-009 avl_read  in  1  read request.
REQ-010 avl_write  in  1  write request.
REQ-011 avl_writedata  in  DATA_W  write data.
REQ-012 avl_wait  out  1  registered waitrequest; commands are not accepted while it is high.
REQ-013 avl_readdata  out  DATA_W  read data, valid only with avl_readdatavalid.
REQ-014 avl_readdatavalid  out  1  one-cycle pulse per accepted read.
REQ-015 err_oor  out  1  sticky flag for an out-of-range access.
REQ-016 err_proto  out  1  sticky flag for avl_read and avl_write high together.
REQ-017 rd_count, wr_count  out  16 each  accepted-read and accepted-write counters; wrap 0xFFFF to 0x0000.

Function
REQ-018 A command is accepted in a cycle where avl_wait=0 and avl_read or avl_write=1.
- While avl_wait=1, the inputs are ignored.
REQ-019 FSM states are IDLE and BUSY.
- IDLE drives avl_wait=0.
- On accept with WAIT_CYCLES>0, go to BUSY and load a down-counter with WAIT_CYCLES.
- BUSY drives avl_wait=1, decrements each cycle, and returns to IDLE after exactly WAIT_CYCLES cycles.
- With WAIT_CYCLES=0, stay in IDLE: back-to-back accepts every cycle.
REQ-020 Write accepted at cycle T: the word is stored at index avl_address[MEM_AW-1:0] and is visible to a read accepted at T+1 or later.
REQ-021 Read accepted at cycle T: avl_readdatavalid=1 for exactly one cycle at T+READ_LATENCY, carrying the addressed word.
- Reads are tracked in a READ_LATENCY-deep valid/data pipeline, so overlapping reads return in order.
REQ-022 avl_readdata holds its last value when avl_readdatavalid=0.
REQ-023 Out of range means avl_address >= 2**MEM_AW.
- Write: dropped.
- Read: returns all-zero data with a normal valid pulse.
- Either case sets err_oor; the counter still increments.
REQ-024 avl_read=1 and avl_write=1 in an accepting cycle: the write is performed, the read is discarded (no valid pulse), err_proto is set, and only wr_count increments.
REQ-025 A read-after-write to the same index accepted in consecutive cycles returns the new data.
REQ-026 Counters increment once per accepted command, never during wait states.

Reset
REQ-027 While iRST_n=0, outputs are forced: avl_wait=1, avl_readdatavalid=0, avl_readdata=0, err_oor=0, err_proto=0, rd_count=0, wr_count=0, FSM=IDLE, read pipeline cleared.
REQ-028 First cycle after release: avl_wait=0.
REQ-029 Reset mid-operation squashes all pending read returns and the wait count.
REQ-030 Memory contents are not cleared by reset.

Structure
REQ-031 Shared package avl_pkg holds the ADDR_W and DATA_W defaults and the IDLE/BUSY state encoding.
REQ-032 The backing store is a sub-module avl_resp_ram.
- Single-port, synchronous write, one-cycle read.
- Inferable as Cyclone V M10K.
- The remaining READ_LATENCY-1 stages live in the responder pipeline.

Verification
REQ-033 Defaults: write 0xA5A5_..._A5A5 at address 0x10, then read 0x10.
- avl_wait high 2 cycles after each accept.
- Valid pulse 2 cycles after the read accept with the same data.
- wr_count=1, rd_count=1.
REQ-034 WAIT_CYCLES=0: reads at addresses 1,2,3 in consecutive cycles.
- Three consecutive valid pulses, in order, with the stored data.
REQ-035 Write to address 0x400 (MEM_AW=10), then read 0x400.
- Read returns 0.
- err_oor=1.
- Index 0 is unchanged.
REQ-036 avl_read and avl_write high together at address 5 with data 0x1234.
- Word 5=0x1234.
- No valid pulse.
- err_proto=1.
- wr_count increments, rd_count does not.
REQ-037 Accept a read, then assert iRST_n=0 one cycle later.
- No valid pulse appears.
- Outputs take their reset values immediately.
- Previously written data is intact after release.
REQ-038 Issue 65536 writes.
- wr_count wraps to 0x0000.
